// File: rtl/hazard_unit_if.sv
// Hazard-unit bus: decode-stage fields and execute-stage redirect in,
// pipeline stall/flush/forward controls and event counters out.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    // Decode-stage instruction fields
    logic [4:0]       rs1d;
    logic [4:0]       rs2d;
    logic [4:0]       rdd;
    logic             regwrited;
    logic [1:0]       resultsrcd;
    // Execute-stage redirect and counter control
    logic             pcsrce;
    logic             cnt_clr;
    // Pipeline controls
    logic             stallf;
    logic             stalld;
    logic             flushd;
    logic             flushe;
    logic [1:0]       forwardae;
    logic [1:0]       forwardbe;
    // Performance counters
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies instruction fields, consumes controls
    modport master (
        output rs1d, rs2d, rdd, regwrited, resultsrcd, pcsrce, cnt_clr,
        input  stallf, stalld, flushd, flushe, forwardae, forwardbe,
        input  stall_cnt, flush_cnt
    );

    // Hazard unit side
    modport slave (
        input  rs1d, rs2d, rdd, regwrited, resultsrcd, pcsrce, cnt_clr,
        output stallf, stalld, flushd, flushe, forwardae, forwardbe,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core. Tracks in-flight
// destinations in a private E/M/W shadow scoreboard that advances with the
// pipeline registers, and derives load-use stalls, control flushes and
// execute-stage forwarding selects from it. Also counts stall/flush cycles.
module hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [4:0] RegX0   = 5'd0;
    localparam logic [1:0] SrcLoad = 2'b01;

    localparam logic [1:0] FwdRf = 2'b00;
    localparam logic [1:0] FwdW  = 2'b01;
    localparam logic [1:0] FwdM  = 2'b10;

    // ------------------------------------------------------------------
    // Shadow scoreboard. Only E keeps sources and the load flag; M and W
    // only need destination and write enable for forwarding decisions.
    // ------------------------------------------------------------------
    logic [4:0] e_rs1_q, e_rs1_d;
    logic [4:0] e_rs2_q, e_rs2_d;
    logic [4:0] e_rd_q, e_rd_d;
    logic       e_regwrite_q, e_regwrite_d;
    logic       e_isload_q, e_isload_d;

    logic [4:0] m_rd_q, m_rd_d;
    logic       m_regwrite_q, m_regwrite_d;

    logic [4:0] w_rd_q, w_rd_d;
    logic       w_regwrite_q, w_regwrite_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lwstall;
    logic stall_evt;
    logic flushe;

    // Hazard detection and stall/flush controls; a redirect overrides a
    // (nominally impossible) simultaneous load-use stall.
    always_comb begin
        lwstall   = e_isload_q && (e_rd_q != RegX0) &&
                    ((e_rd_q == hz.rs1d) || (e_rd_q == hz.rs2d));
        stall_evt = lwstall && !hz.pcsrce;
        flushe    = lwstall || hz.pcsrce;

        hz.stallf = stall_evt;
        hz.stalld = stall_evt;
        hz.flushd = hz.pcsrce;
        hz.flushe = flushe;
    end

    // Forwarding selects for both execute operands; M beats W, x0 never forwards.
    always_comb begin
        hz.forwardae = FwdRf;
        hz.forwardbe = FwdRf;

        if (m_regwrite_q && (m_rd_q != RegX0) && (m_rd_q == e_rs1_q)) begin
            hz.forwardae = FwdM;
        end else if (w_regwrite_q && (w_rd_q != RegX0) && (w_rd_q == e_rs1_q)) begin
            hz.forwardae = FwdW;
        end

        if (m_regwrite_q && (m_rd_q != RegX0) && (m_rd_q == e_rs2_q)) begin
            hz.forwardbe = FwdM;
        end else if (w_regwrite_q && (w_rd_q != RegX0) && (w_rd_q == e_rs2_q)) begin
            hz.forwardbe = FwdW;
        end
    end

    // Next shadow state: E takes the decode instruction or a bubble, M/W shift.
    always_comb begin
        e_rs1_d      = hz.rs1d;
        e_rs2_d      = hz.rs2d;
        e_rd_d       = hz.rdd;
        e_regwrite_d = hz.regwrited;
        e_isload_d   = (hz.resultsrcd == SrcLoad);

        if (flushe) begin
            e_rs1_d      = RegX0;
            e_rs2_d      = RegX0;
            e_rd_d       = RegX0;
            e_regwrite_d = 1'b0;
            e_isload_d   = 1'b0;
        end

        m_rd_d       = e_rd_q;
        m_regwrite_d = e_regwrite_q;
        w_rd_d       = m_rd_q;
        w_regwrite_d = m_regwrite_q;
    end

    // Next counter values: clear wins, otherwise saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (hz.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (hz.pcsrce && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Shadow scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rs1_q      <= '0;
            e_rs2_q      <= '0;
            e_rd_q       <= '0;
            e_regwrite_q <= 1'b0;
            e_isload_q   <= 1'b0;
            m_rd_q       <= '0;
            m_regwrite_q <= 1'b0;
            w_rd_q       <= '0;
            w_regwrite_q <= 1'b0;
        end else begin
            e_rs1_q      <= e_rs1_d;
            e_rs2_q      <= e_rs2_d;
            e_rd_q       <= e_rd_d;
            e_regwrite_q <= e_regwrite_d;
            e_isload_q   <= e_isload_d;
            m_rd_q       <= m_rd_d;
            m_regwrite_q <= m_regwrite_d;
            w_rd_q       <= w_rd_d;
            w_regwrite_q <= w_regwrite_d;
        end
    end

    // Event counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counter outputs.
    always_comb begin
        hz.stall_cnt = stall_cnt_q;
        hz.flush_cnt = flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed test-plan scenarios plus
// randomized instruction streams, checked against an instruction-level model.
module tb_hazard_unit;

    localparam int unsigned CNT_W   = 6;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    hazard_unit_if #(.CNT_W(CNT_W)) u_if ();

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model: the three instructions in flight beyond decode.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t pipe[3];  // 0 = E, 1 = M, 2 = W
    int     m_stall_cnt;
    int     m_flush_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 1'b0, 1'b0};
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    function automatic bit m_lwstall();
        return pipe[0].ld && pipe[0].rd != 0 &&
               (pipe[0].rd == int'(u_if.rs1d) || pipe[0].rd == int'(u_if.rs2d));
    endfunction

    function automatic int m_fwd(input int src);
        if (pipe[1].wr && pipe[1].rd != 0 && pipe[1].rd == src) return 2;
        if (pipe[2].wr && pipe[2].rd != 0 && pipe[2].rd == src) return 1;
        return 0;
    endfunction

    task automatic drive(input int rs1, input int rs2, input int rd, input bit wr,
                         input int rsrc, input bit pc, input bit clr);
        u_if.rs1d       = 5'(rs1);
        u_if.rs2d       = 5'(rs2);
        u_if.rdd        = 5'(rd);
        u_if.regwrited  = wr;
        u_if.resultsrcd = 2'(rsrc);
        u_if.pcsrce     = pc;
        u_if.cnt_clr    = clr;
    endtask

    // Compare every DUT output with the model mid-cycle.
    task automatic check_model();
        bit st;
        @(negedge clk);
        st = m_lwstall() && !u_if.pcsrce;
        check_eq("stallf", u_if.stallf, st);
        check_eq("stalld", u_if.stalld, st);
        check_eq("flushd", u_if.flushd, u_if.pcsrce);
        check_eq("flushe", u_if.flushe, m_lwstall() || u_if.pcsrce);
        check_eq("forwardae", u_if.forwardae, m_fwd(pipe[0].rs1));
        check_eq("forwardbe", u_if.forwardbe, m_fwd(pipe[0].rs2));
        check_eq("stall_cnt", u_if.stall_cnt, m_stall_cnt);
        check_eq("flush_cnt", u_if.flush_cnt, m_flush_cnt);
    endtask

    // Clock edge: shift the model pipeline, then move inputs off the edge.
    task automatic advance();
        bit st, fl;
        instr_t nxt;
        @(posedge clk);
        st = m_lwstall() && !u_if.pcsrce;
        fl = m_lwstall() || u_if.pcsrce;
        nxt = '{int'(u_if.rs1d), int'(u_if.rs2d), int'(u_if.rdd), u_if.regwrited,
                u_if.resultsrcd == 2'b01};
        if (fl) nxt = '{0, 0, 0, 1'b0, 1'b0};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        if (u_if.cnt_clr) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (st && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (u_if.pcsrce && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end
        #1;
    endtask

    task automatic step();
        check_model();
        advance();
    endtask

    task automatic nop();
        drive(0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        nop();
        u_if.pcsrce = 1'b1;
        #2;
        check_eq("rst_stallf", u_if.stallf, 1'b0);
        check_eq("rst_fwd_a", u_if.forwardae, 2'b00);
        check_eq("rst_flushe_follows_pc", u_if.flushe, 1'b1);
        check_eq("rst_stall_cnt", u_if.stall_cnt, 0);
        nop();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forward from M
        drive(0, 0, 5, 1'b1, 0, 1'b0, 1'b0); step();   // add x5
        drive(5, 6, 8, 1'b1, 0, 1'b0, 1'b0); step();   // uses x5
        nop(); check_model();
        check_eq("fwd_m_a", u_if.forwardae, 2'b10);
        check_eq("fwd_m_b", u_if.forwardbe, 2'b00);
        check_eq("fwd_m_nostall", u_if.stallf, 1'b0);
        advance();
        step(); step();

        // M over W, then W only
        drive(0, 0, 7, 1'b1, 0, 1'b0, 1'b0); step();
        drive(0, 0, 7, 1'b1, 0, 1'b0, 1'b0); step();
        drive(7, 0, 9, 1'b1, 0, 1'b0, 1'b0); step();
        nop(); check_model();
        check_eq("fwd_m_over_w", u_if.forwardae, 2'b10);
        advance();
        drive(0, 0, 7, 1'b1, 0, 1'b0, 1'b0); step();
        drive(0, 0, 9, 1'b1, 0, 1'b0, 1'b0); step();
        drive(7, 0, 10, 1'b1, 0, 1'b0, 1'b0); step();
        nop(); check_model();
        check_eq("fwd_w", u_if.forwardae, 2'b01);
        advance();
        step(); step();

        // Load-use on rs2
        drive(0, 0, 3, 1'b1, 1, 1'b0, 1'b0); step();   // lw x3
        drive(0, 3, 4, 1'b1, 0, 1'b0, 1'b0); check_model();
        check_eq("lu_stallf", u_if.stallf, 1'b1);
        check_eq("lu_flushe", u_if.flushe, 1'b1);
        advance();
        check_model();                                 // same D held
        check_eq("lu_one_cycle", u_if.stallf, 1'b0);
        advance();
        nop(); check_model();
        check_eq("lu_fwd_w", u_if.forwardbe, 2'b01);
        check_eq("lu_stall_cnt", u_if.stall_cnt, 1);
        advance();
        step(); step();

        // x0 guard
        drive(0, 0, 0, 1'b1, 1, 1'b0, 1'b0); step();   // lw x0
        drive(0, 0, 0, 1'b1, 0, 1'b0, 1'b0); check_model();
        check_eq("x0_nostall", u_if.stallf, 1'b0);
        advance();
        drive(0, 0, 11, 1'b1, 0, 1'b0, 1'b0); step();  // uses x0 after add x0
        nop(); check_model();
        check_eq("x0_nofwd", u_if.forwardae, 2'b00);
        advance();
        step(); step();

        // Branch flush
        drive(0, 0, 12, 1'b1, 0, 1'b0, 1'b0); step();
        drive(12, 12, 13, 1'b1, 0, 1'b1, 1'b0); check_model();
        check_eq("br_flushd", u_if.flushd, 1'b1);
        check_eq("br_flushe", u_if.flushe, 1'b1);
        check_eq("br_nostall", u_if.stallf, 1'b0);
        advance();
        drive(13, 13, 14, 1'b1, 0, 1'b0, 1'b0); step();
        nop(); check_model();
        check_eq("br_flush_cnt", u_if.flush_cnt, 1);
        advance();

        // Load-use and redirect together: redirect wins
        drive(0, 0, 2, 1'b1, 1, 1'b0, 1'b0); step();
        drive(2, 0, 3, 1'b1, 0, 1'b1, 1'b0); check_model();
        check_eq("both_nostall", u_if.stallf, 1'b0);
        check_eq("both_flushd", u_if.flushd, 1'b1);
        advance();

        // Randomized instruction streams
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0);
            step();
        end

        // Saturate stall counter: lw x1 depending on x1 stalls every other cycle
        drive(1, 0, 1, 1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * (CNT_MAX + 4) + 2; i++) step();
        check_model();
        check_eq("stall_sat", u_if.stall_cnt, CNT_MAX);
        advance();

        // cnt_clr together with a stall event
        drive(0, 0, 1, 1'b1, 1, 1'b0, 1'b0); step();
        drive(1, 0, 1, 1'b1, 1, 1'b0, 1'b1); check_model();
        check_eq("clr_evt_stall", u_if.stallf, 1'b1);
        advance();
        nop(); check_model();
        check_eq("clr_stall_cnt", u_if.stall_cnt, 0);
        check_eq("clr_flush_cnt", u_if.flush_cnt, 0);
        advance();

        // Reset mid-stall
        drive(0, 0, 4, 1'b1, 1, 1'b0, 1'b0); step();
        drive(4, 0, 5, 1'b1, 0, 1'b0, 1'b0);
        #1;
        check_eq("pre_rst_stall", u_if.stallf, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_stallf", u_if.stallf, 1'b0);
        check_eq("rst_mid_flushe", u_if.flushe, 1'b0);
        check_eq("rst_mid_fwd_b", u_if.forwardbe, 2'b00);
        check_eq("rst_mid_stall_cnt", u_if.stall_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 5) == 0, 1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core: the block that drives the `clr` input of the ID/EX register and the stall/flush controls of the fetch and decode stages, and selects the execute-stage operand forwarding paths. Instead of taking E/M/W destination fields from the pipeline, it keeps its own shadow scoreboard of in-flight destinations (E, M, W slots) that advances in lock-step with the pipeline registers and applies the same bubble/flush rules. It also provides saturating stall and flush event counters for performance monitoring.

## Interface
- Parameters:
- CNT_W, 16, width of the stall and flush event counters
- Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- rs1d  input  5  decode-stage source register 1
- rs2d  input  5  decode-stage source register 2
- rdd  input  5  decode-stage destination register
- regwrited  input  1  decode-stage register-write enable
- resultsrcd  input  2  decode-stage result select; 2'b01 means load
- pcsrce  input  1  taken branch or jump resolved in execute
- cnt_clr  input  1  synchronous clear of both event counters
- stallf  output  1  hold PC register
- stalld  output  1  hold IF/ID register
- flushd  output  1  clear IF/ID register
- flushe  output  1  clear ID/EX register (drives its `clr`)
- forwardae  output  2  operand A select: 00 register file, 10 M-stage ALU result, 01 W-stage result
- forwardbe  output  2  operand B select, same encoding
- stall_cnt  output  CNT_W  cycles with load-use stall
- flush_cnt  output  CNT_W  cycles with control flush

## Operation
- Shadow slots E, M, W each hold {rs1, rs2, rd, regwrite, isload}. Only the E slot uses rs1/rs2.
- Shadow advance on every clock edge:
  - If flushe is asserted, E loads a bubble: all fields are 0.
  - Otherwise E loads {rs1d, rs2d, rdd, regwrited, resultsrcd==2'b01}.
  - M loads E. W loads M.
  - There is no stall input to M or W. Stalls freeze only F and D, and E receives a bubble during a stall.
- Load-use hazard: lwstall = E.isload & (E.rd != 0) & (E.rd == rs1d | E.rd == rs2d).
- Control outputs, all combinational from the shadow state and inputs:
  - stallf = stalld = lwstall & ~pcsrce
  - flushd = pcsrce
  - flushe = lwstall | pcsrce
- lwstall and pcsrce cannot both be true in a legal program, because E holds either a load or a branch/jump. If both are seen anyway, pcsrce takes priority: stalls are deasserted and both flushes are asserted.
- Forwarding for operand A (operand B is identical, using E.rs2):
  - 10 if M.regwrite & M.rd != 0 & M.rd == E.rs1
  - otherwise 01 if W.regwrite & W.rd != 0 & W.rd == E.rs1
  - otherwise 00
  - M has priority over W.
- Register x0 never triggers forwarding or stall.
- Counters:
  - stall_cnt increments on each cycle where lwstall & ~pcsrce.
  - flush_cnt increments on each cycle where pcsrce.
  - Both saturate at all-ones; they do not wrap.
  - cnt_clr zeroes both counters on the next edge and has priority over increment.

## Timing
- Reset (async, rst_n low): all shadow fields are 0, so stallf = stalld = 0, forwardae = forwardbe = 00, and flushd = flushe = pcsrce. Both counters are 0.
- Reset deasserted mid-operation: the shadow state restarts empty. No forwarding or stall is raised until new instructions enter the E slot.
- Control and forward outputs are combinational, valid in the same cycle as their inputs, with zero latency. They are consumed at the next clock edge by the pipeline registers.
- A load-use stall lasts exactly one cycle. On the next cycle E holds a bubble, so lwstall drops, and the dependent instruction then forwards from W (01) while the load result sits in W.
- A taken branch produces exactly one cycle of flushd/flushe per pcsrce cycle.
- Counter values are visible one cycle after the counted event.

## Test plan
- Forward from M: x5 = add (E); the next instruction uses rs1 = x5 → in the second cycle forwardae = 10, forwardbe = 00, no stall.
- Forward from W, and M over W: write x7 in instruction i and i+1, use x7 in i+2 → forwardae = 10. Write x7 in i only, use x7 in i+2 → forwardae = 01.
- Load-use: lw x3 in E, rs2d = 3 → stallf = stalld = flushe = 1 for one cycle. Next cycle all deasserted, then forwardbe = 01. stall_cnt = 1.
- x0 guard: lw x0 in E, rs1d = 0 → no stall. add to x0 then use x0 → forwardae = 00.
- Branch flush: pcsrce = 1 for one cycle → flushd = flushe = 1 and stalls 0. E slot becomes a bubble, so forwarding is 00 on the next two instructions. flush_cnt = 1.
- Counters and reset: force 2^CNT_W + 3 stall cycles → stall_cnt stays at all-ones. Assert cnt_clr together with an event → both counters read 0. Assert rst_n low mid-stall → outputs go to reset values immediately.
